// File: rtl/jstk_pkg.sv
// ---------------------------------------------------------------------------
// jstk_pkg
// Shared constants for the PmodJSTK joystick SPI reader and its responder.
//   - Frame geometry: 40 bits, 5 bytes, MSB of byte0 first on the wire.
//   - Byte-index constants, so the reader's field decode and the responder's
//     frame packing agree on the layout.
//   - Responder FSM state encoding.
//   - Default LED command prefix (command byte bits [7:2]).
// ---------------------------------------------------------------------------
package jstk_pkg;

    localparam int FRAME_BITS  = 40;
    localparam int FRAME_BYTES = 5;

    // Byte positions within the frame; byte0 goes out first.
    localparam int BYTE_X_LO = 0;
    localparam int BYTE_X_HI = 1;
    localparam int BYTE_Y_LO = 2;
    localparam int BYTE_Y_HI = 3;
    localparam int BYTE_BTN  = 4;

    localparam logic [5:0] CMD_PREFIX_DEFAULT = 6'b100000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } jstk_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// ---------------------------------------------------------------------------
// spi_sync_edge
// Multi-flop synchronizer for one asynchronous SPI line, with single-cycle
// rise/fall pulses derived from the synchronized level.
// Ports:
//   clk      - system clock
//   clr      - synchronous active-low reset (chain loads IDLE_LEVEL)
//   i_async  - raw asynchronous input
//   o_level  - synchronized level (STAGES cycles of latency)
//   o_rise   - one-cycle pulse on a synchronized 0->1 transition
//   o_fall   - one-cycle pulse on a synchronized 1->0 transition
// Parameters:
//   STAGES     - synchronizer depth (>= 2)
//   IDLE_LEVEL - value loaded on reset, so no edge is seen leaving reset
//                while the line sits at its idle level
// ---------------------------------------------------------------------------
module spi_sync_edge #(
    parameter int   STAGES     = 2,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic clr,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge clk) begin
        if (!clr) begin
            r_sync <= {STAGES{IDLE_LEVEL}};
            r_prev <= IDLE_LEVEL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_level = r_sync[STAGES-1];
    assign o_rise  =  r_sync[STAGES-1] & ~r_prev;
    assign o_fall  = ~r_sync[STAGES-1] &  r_prev;

endmodule

// File: rtl/jstk_spi_responder.sv
// ---------------------------------------------------------------------------
// jstk_spi_responder
// SPI slave (mode 0) emulating the PmodJSTK joystick. Serves a 40-bit
// position/button frame on MISO and captures the LED command byte on MOSI.
// Ports:
//   clk, clr       - system clock, synchronous active-low reset
//   sclk, ss, mosi - raw SPI lines from the master (asynchronous)
//   miso, miso_oe  - serial data to master and its drive enable
//   joy_x, joy_y   - 10-bit positions; joy_btn = {left, right, stick}
//   led_cmd        - last accepted LED command {LED1, LED0}
//   frame_done     - pulse after a complete 40-bit frame and SS release
//   frame_err      - pulse when SS releases before 40 bits
// Optional build macro JSTK_RESP_FRAMECNT_EN: byte4[7:3] carries a 5-bit
// wrapping count of completed frames (value before this frame's increment).
// Without it byte4[7:3] is zero and no counter exists.
// ---------------------------------------------------------------------------
module jstk_spi_responder
    import jstk_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [5:0] CMD_PREFIX  = CMD_PREFIX_DEFAULT
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       sclk,
    input  logic       ss,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    input  logic [9:0] joy_x,
    input  logic [9:0] joy_y,
    input  logic [2:0] joy_btn,
    output logic [1:0] led_cmd,
    output logic       frame_done,
    output logic       frame_err
);

    localparam logic [5:0] CNT_FULL = 6'(FRAME_BITS);
    localparam logic [5:0] CNT_CMD  = 6'd8;

    logic w_sclk_q, w_sclk_rise, w_sclk_fall;
    logic w_ss_q,   w_ss_rise,   w_ss_fall;
    logic w_mosi_q, w_mosi_rise, w_mosi_fall;
    logic w_unused;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_sync_sclk (
        .clk(clk), .clr(clr), .i_async(sclk),
        .o_level(w_sclk_q), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_sync_ss (
        .clk(clk), .clr(clr), .i_async(ss),
        .o_level(w_ss_q), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_sync_mosi (
        .clk(clk), .clr(clr), .i_async(mosi),
        .o_level(w_mosi_q), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
    );

    // Only edges of sclk/ss and the level of mosi drive the protocol.
    assign w_unused = ^{w_sclk_q, w_ss_q, w_mosi_rise, w_mosi_fall};

    jstk_state_t r_state;
    logic [39:0] r_shift;
    logic [5:0]  r_cnt;
    logic [7:0]  r_cmd;
    logic        r_miso;
    logic        r_miso_oe;
    logic [1:0]  r_led_cmd;
    logic        r_frame_done;
    logic        r_frame_err;
    logic [7:0]  w_byte4;
    logic [39:0] w_frame;

`ifdef JSTK_RESP_FRAMECNT_EN
    logic [4:0]  r_frame_cnt;
    assign w_byte4 = {r_frame_cnt, joy_btn};
`else
    assign w_byte4 = {5'b0, joy_btn};
`endif

    assign w_frame = {joy_x[7:0], 6'b0, joy_x[9:8],
                      joy_y[7:0], 6'b0, joy_y[9:8],
                      w_byte4};

    always_ff @(posedge clk) begin
        if (!clr) begin
            r_state      <= IDLE;
            r_shift      <= '0;
            r_cnt        <= '0;
            r_cmd        <= '0;
            r_miso       <= 1'b0;
            r_miso_oe    <= 1'b0;
            r_led_cmd    <= 2'b00;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
`ifdef JSTK_RESP_FRAMECNT_EN
            r_frame_cnt  <= '0;
`endif
        end else begin
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_ss_fall) begin
                        // Snapshot keeps the frame coherent if inputs move mid-frame.
                        r_shift   <= w_frame;
                        r_miso    <= w_frame[39];
                        r_miso_oe <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    // SS release takes priority over any coincident SCLK edge.
                    if (w_ss_rise) begin
                        if (r_cnt == CNT_FULL) begin
                            r_state <= DONE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_miso_oe   <= 1'b0;
                            r_miso      <= 1'b0;
                            r_state     <= IDLE;
                        end
                    end else if (w_sclk_rise) begin
                        if (r_cnt < CNT_FULL) begin
                            if (r_cnt < CNT_CMD) begin
                                r_cmd <= {r_cmd[6:0], w_mosi_q};
                            end
                            r_cnt <= r_cnt + 6'd1;
                        end else begin
                            r_miso <= 1'b0;
                        end
                    end else if (w_sclk_fall) begin
                        if (r_cnt < CNT_FULL) begin
                            r_shift <= {r_shift[38:0], 1'b0};
                            r_miso  <= r_shift[38];
                        end else begin
                            r_miso <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    r_frame_done <= 1'b1;
                    if (r_cmd[7:2] == CMD_PREFIX) begin
                        r_led_cmd <= r_cmd[1:0];
                    end
`ifdef JSTK_RESP_FRAMECNT_EN
                    r_frame_cnt <= r_frame_cnt + 5'd1;
`endif
                    r_miso_oe <= 1'b0;
                    r_miso    <= 1'b0;
                    r_state   <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign miso       = r_miso;
    assign miso_oe    = r_miso_oe;
    assign led_cmd    = r_led_cmd;
    assign frame_done = r_frame_done;
    assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_jstk_spi_responder.sv
// ---------------------------------------------------------------------------
// tb_jstk_spi_responder
// Bench for jstk_spi_responder: drives mode-0 SPI frames as the master,
// checks received frames against a scoreboard queue, and checks the
// frame_done/frame_err pulse counts and led_cmd after each frame.
// Define JSTK_RESP_FRAMECNT_EN for both bench and RTL to exercise the
// frame counter in byte4[7:3].
// ---------------------------------------------------------------------------
module tb_jstk_spi_responder;

    localparam int HALF = 6;   // clk cycles per SCLK half period
    localparam int GAP  = 10;  // clk cycles of SS high between frames

    logic       clk = 1'b0;
    logic       clr;
    logic       sclk;
    logic       ss;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic [9:0] joy_x;
    logic [9:0] joy_y;
    logic [2:0] joy_btn;
    logic [1:0] led_cmd;
    logic       frame_done;
    logic       frame_err;

    always #10 clk = ~clk;

    jstk_spi_responder #(.SYNC_STAGES(2), .CMD_PREFIX(6'b100000)) dut (
        .clk(clk), .clr(clr), .sclk(sclk), .ss(ss), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe),
        .joy_x(joy_x), .joy_y(joy_y), .joy_btn(joy_btn),
        .led_cmd(led_cmd), .frame_done(frame_done), .frame_err(frame_err)
    );

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [2:0]  btn;
        logic [7:0]  cmd;
        logic [39:0] frame;
        logic [1:0]  led;
    } vec_t;

    vec_t        vecs[6];
    logic [39:0] exp_q[$];
    logic [4:0]  exp_fcnt;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          done_cnt = 0;
    int          err_cnt  = 0;

    always @(negedge clk) begin
        if (frame_done) done_cnt++;
        if (frame_err)  err_cnt++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
            $display("ok   %s act=%0h exp=%0h", name, act, exp);
        end else begin
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Master side of one frame. nbits SCLK cycles; joy_x switches to chg_x
    // at bit chg_at; rst_at_end asserts clr together with SS release.
    task automatic spi_frame(input logic [7:0] cmd, input int nbits, input int chg_at,
                             input logic [9:0] chg_x, input bit rst_at_end,
                             output logic [39:0] rx);
        logic [7:0] cmd_sh;
        rx = '0;
        cmd_sh = cmd;
        @(negedge clk);
        ss = 1'b0;
        mosi = cmd_sh[7];
        repeat (HALF) @(negedge clk);
        for (int b = 0; b < nbits; b++) begin
            sclk = 1'b1;
            rx = {rx[38:0], miso};
            if (b == 0) check("oe_during_frame", 64'(miso_oe), 64'd1);
            if (b == chg_at) joy_x = chg_x;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
            cmd_sh = {cmd_sh[6:0], 1'b0};
            mosi = cmd_sh[7];
            repeat (HALF) @(negedge clk);
        end
        if (rst_at_end) clr = 1'b0;
        ss = 1'b1;
        repeat (4) @(negedge clk);
        check("oe_off_after_ss", 64'(miso_oe), 64'd0);
        repeat (GAP - 4) @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v, input string tag, input int chg_at,
                           input logic [9:0] chg_x, output logic [39:0] rx);
        logic [39:0] exp;
        int d0, e0;
        exp = v.frame;
`ifdef JSTK_RESP_FRAMECNT_EN
        exp[7:3] = exp_fcnt;
`endif
        exp_q.push_back(exp);
        joy_x = v.x;
        joy_y = v.y;
        joy_btn = v.btn;
        d0 = done_cnt;
        e0 = err_cnt;
        spi_frame(v.cmd, 40, chg_at, chg_x, 1'b0, rx);
        if (exp_q.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 64'd0, 64'd1);
        end else begin
            check({tag, "_frame"}, 64'(rx), 64'(exp_q.pop_front()));
        end
        check({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
        check({tag, "_err_pulses"}, 64'(err_cnt - e0), 64'd0);
        check({tag, "_led"}, 64'(led_cmd), 64'(v.led));
        exp_fcnt = exp_fcnt + 5'd1;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [39:0] rx;
        vec_t        v;
        int          d0, e0;

        vecs[0] = '{10'h2A5, 10'h13C, 3'b011, 8'h83, 40'hA5_02_3C_01_03, 2'b11};
        vecs[1] = '{10'h2A5, 10'h13C, 3'b011, 8'h03, 40'hA5_02_3C_01_03, 2'b11};
        vecs[2] = '{10'h0FF, 10'h300, 3'b100, 8'h81, 40'hFF_00_00_03_04, 2'b01};
        vecs[3] = '{10'h3FF, 10'h3FF, 3'b111, 8'h82, 40'hFF_03_FF_03_07, 2'b10};
        vecs[4] = '{10'h000, 10'h000, 3'b000, 8'h80, 40'h00_00_00_00_00, 2'b00};
        vecs[5] = '{10'h155, 10'h2AA, 3'b101, 8'hFF, 40'h55_01_AA_02_05, 2'b00};

        clr = 1'b0; ss = 1'b1; sclk = 1'b0; mosi = 1'b0;
        joy_x = '0; joy_y = '0; joy_btn = '0;
        exp_fcnt = '0;
        repeat (5) @(negedge clk);
        check("rst_miso", 64'(miso), 64'd0);
        check("rst_miso_oe", 64'(miso_oe), 64'd0);
        check("rst_led", 64'(led_cmd), 64'd0);
        check("rst_done", 64'(frame_done), 64'd0);
        check("rst_err", 64'(frame_err), 64'd0);
        clr = 1'b1;
        repeat (5) @(negedge clk);

        // Table-driven frames.
        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i), -1, 10'h0, rx);
        end

        // Early abort after 17 SCLK cycles with a command that would set LEDs.
        joy_x = 10'h2A5; joy_y = 10'h13C; joy_btn = 3'b011;
        d0 = done_cnt; e0 = err_cnt;
        spi_frame(8'h83, 17, -1, 10'h0, 1'b0, rx);
        check("abort_err_pulses", 64'(err_cnt - e0), 64'd1);
        check("abort_done_pulses", 64'(done_cnt - d0), 64'd0);
        check("abort_led", 64'(led_cmd), 64'd0);

        // Snapshot coherence: joy_x drops to 0 at bit 12.
        v = '{10'h3FF, 10'h000, 3'b000, 8'h82, 40'hFF_03_00_00_00, 2'b10};
        run_vec(v, "snapshot", 12, 10'h000, rx);

        // Reset at bit 20, then a clean frame.
        joy_x = 10'h155;
        d0 = done_cnt; e0 = err_cnt;
        spi_frame(8'h83, 20, -1, 10'h0, 1'b1, rx);
        check("midrst_led", 64'(led_cmd), 64'd0);
        check("midrst_miso", 64'(miso), 64'd0);
        clr = 1'b1;
        exp_fcnt = '0;
        repeat (6) @(negedge clk);
        check("midrst_err_pulses", 64'(err_cnt - e0), 64'd0);
        check("midrst_done_pulses", 64'(done_cnt - d0), 64'd0);
        v = '{10'h001, 10'h000, 3'b000, 8'h81, 40'h01_00_00_00_00, 2'b01};
        run_vec(v, "after_rst", -1, 10'h0, rx);

`ifdef JSTK_RESP_FRAMECNT_EN
        // Frame counter: 33 frames from reset read 0..31, 0.
        clr = 1'b0;
        repeat (4) @(negedge clk);
        clr = 1'b1;
        exp_fcnt = '0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 33; i++) begin
            logic [4:0] want;
            want = 5'(i % 32);
            run_vec(vecs[2], $sformatf("fcnt%0d", i), -1, 10'h0, rx);
            check($sformatf("fcnt%0d_byte4hi", i), 64'(rx[7:3]), 64'(want));
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
